// File: rtl/pattern_response_misr.sv
// pattern_response_misr: folds accepted response vectors into a MISR over a fixed window
// and offers the final signature through a valid/ready handshake.
module pattern_response_misr #(
    parameter int                   RESP_WIDTH = 11,
    parameter int                   SIG_WIDTH  = 16,
    parameter logic [SIG_WIDTH-1:0] POLY       = 16'h1021,
    parameter logic [SIG_WIDTH-1:0] SEED       = 16'hFFFF,
    parameter int                   WINDOW     = 256
) (
    input  logic                  blif_clk_net,
    input  logic                  blif_reset_net,
    input  logic                  start,
    input  logic [RESP_WIDTH-1:0] resp_in,
    input  logic                  resp_valid,
    output logic                  busy,
    output logic [15:0]           sample_cnt,
    output logic [SIG_WIDTH-1:0]  sig_out,
    output logic                  sig_valid,
    input  logic                  sig_ready
);
    typedef enum logic [1:0] {IDLE, CAPTURE, HOLD} state_t;
    state_t                 r_state, w_next;
    logic [SIG_WIDTH-1:0]   r_sig, w_step;
    logic [15:0]            r_cnt;
    logic                   w_accept, w_last;
    always_comb begin
        w_accept = (r_state == CAPTURE) && resp_valid;
        w_last   = r_cnt == 16'(WINDOW - 1);
        w_step   = {r_sig[SIG_WIDTH-2:0], 1'b0} ^ (r_sig[SIG_WIDTH-1] ? POLY : '0) ^ SIG_WIDTH'(resp_in);
        w_next   = (r_state == IDLE && start)            ? CAPTURE :
                   (w_accept && w_last)                  ? HOLD    :
                   (r_state == HOLD && sig_ready)        ? IDLE    : r_state;
    end
    always_ff @(posedge blif_clk_net)
        r_state <= blif_reset_net ? IDLE : w_next;
    always_ff @(posedge blif_clk_net) begin
        if (blif_reset_net) begin
            r_sig <= SEED;
            r_cnt <= '0;
        end else if (r_state == IDLE && start) begin
            r_sig <= SEED;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_sig <= w_step;
            r_cnt <= r_cnt + 16'd1;
        end
    end
    assign busy       = r_state == CAPTURE;
    assign sig_valid  = r_state == HOLD;
    assign sig_out    = r_sig;
    assign sample_cnt = r_cnt;
endmodule

// File: tb/tb_pattern_response_misr.sv
// tb_pattern_response_misr: directed and randomized checks of three MISR instances (windows 1, 2, 256).
module tb_pattern_response_misr;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  st  = '0, rv = '0, rdy = '0, bz, sv;
    logic [10:0] ri [3];
    logic [15:0] cn [3];
    logic [15:0] sg [3];
    logic [10:0] vecs [256];
    logic [15:0] model, r100;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    pattern_response_misr #(.WINDOW(1)) u0 (
        .blif_clk_net(clk), .blif_reset_net(rst), .start(st[0]), .resp_in(ri[0]), .resp_valid(rv[0]),
        .busy(bz[0]), .sample_cnt(cn[0]), .sig_out(sg[0]), .sig_valid(sv[0]), .sig_ready(rdy[0]));
    pattern_response_misr #(.WINDOW(2)) u1 (
        .blif_clk_net(clk), .blif_reset_net(rst), .start(st[1]), .resp_in(ri[1]), .resp_valid(rv[1]),
        .busy(bz[1]), .sample_cnt(cn[1]), .sig_out(sg[1]), .sig_valid(sv[1]), .sig_ready(rdy[1]));
    pattern_response_misr #(.WINDOW(256)) u2 (
        .blif_clk_net(clk), .blif_reset_net(rst), .start(st[2]), .resp_in(ri[2]), .resp_valid(rv[2]),
        .busy(bz[2]), .sample_cnt(cn[2]), .sig_out(sg[2]), .sig_valid(sv[2]), .sig_ready(rdy[2]));

    // Signature step as polynomial arithmetic: multiply by x, reduce mod x^16+POLY, add the response.
    function automatic logic [15:0] mstep(input logic [15:0] s, input logic [10:0] r);
        int v = int'(s) * 2;
        if (v >= 65536) v = (v - 65536) ^ 32'h1021;
        return 16'(v) ^ {5'b0, r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string t, input logic [15:0] o, input logic [15:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", t, o, e);
        end
    endtask

    task automatic st_chk(input int k, input logic b, input logic v, input logic [15:0] c,
                          input logic [15:0] s, input string t);
        chk({t, "_busy"}, 16'(bz[k]), 16'(b));
        chk({t, "_valid"}, 16'(sv[k]), 16'(v));
        chk({t, "_cnt"}, cn[k], c);
        chk({t, "_sig"}, sg[k], s);
    endtask

    task automatic feed(input logic [10:0] v);
        if ($urandom_range(0, 3) == 0) begin
            rv[2] = 1'b0;
            ri[2] = 11'($urandom);
            tick();
        end
        rv[2] = 1'b1;
        ri[2] = v;
        tick();
        rv[2] = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) ri[k] = '0;
        for (int i = 0; i < 256; i++) vecs[i] = 11'($urandom);
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) st_chk(k, 0, 0, 0, 16'hFFFF, "reset");
        // T1: window of one zero sample
        st[0] = 1'b1; tick(); st[0] = 1'b0;
        st_chk(0, 1, 0, 0, 16'hFFFF, "t1_start");
        rv[0] = 1'b1; ri[0] = '0; tick(); rv[0] = 1'b0;
        st_chk(0, 0, 1, 1, 16'hEFDF, "t1_hold");
        // T5 in HOLD: start and resp_valid ignored
        st[0] = 1'b1; rv[0] = 1'b1; ri[0] = 11'h5A5;
        tick(); tick();
        st[0] = 1'b0; rv[0] = 1'b0;
        st_chk(0, 0, 1, 1, 16'hEFDF, "t5_hold");
        // T3: backpressure
        for (int i = 0; i < 5; i++) begin
            tick();
            st_chk(0, 0, 1, 1, 16'hEFDF, "t3_bp");
        end
        rdy[0] = 1'b1; tick(); rdy[0] = 1'b0;
        st_chk(0, 0, 0, 1, 16'hEFDF, "t3_release");
        // T5 in IDLE: resp_valid ignored, sig_ready ignored
        rv[0] = 1'b1; ri[0] = 11'h3FF; rdy[0] = 1'b1;
        tick(); tick();
        rv[0] = 1'b0; rdy[0] = 1'b0;
        st_chk(0, 0, 0, 1, 16'hEFDF, "t5_idle");
        // start together with resp_valid in IDLE: only the start is taken
        st[0] = 1'b1; rv[0] = 1'b1; ri[0] = 11'h005; tick(); st[0] = 1'b0; rv[0] = 1'b0;
        st_chk(0, 1, 0, 0, 16'hFFFF, "t5_start_rv");
        rv[0] = 1'b1; ri[0] = 11'h001; tick(); rv[0] = 1'b0;
        st_chk(0, 0, 1, 1, mstep(16'hFFFF, 11'h001), "t1b_hold");
        // T2: two zero samples with idle gap, start ignored in CAPTURE
        st[1] = 1'b1; tick(); st[1] = 1'b0;
        rv[1] = 1'b1; ri[1] = '0; tick(); rv[1] = 1'b0;
        st_chk(1, 1, 0, 1, 16'hEFDF, "t2_first");
        for (int i = 0; i < 3; i++) begin
            ri[1] = 11'($urandom);
            st[1] = (i == 1);
            tick();
            st_chk(1, 1, 0, 1, 16'hEFDF, "t2_idle");
        end
        st[1] = 1'b0;
        rv[1] = 1'b1; ri[1] = '0; tick(); rv[1] = 1'b0;
        st_chk(1, 0, 1, 2, 16'hCF9F, "t2_hold");
        rdy[1] = 1'b1; tick(); rdy[1] = 1'b0;
        st_chk(1, 0, 0, 2, 16'hCF9F, "t2_release");
        // T4: reset after 100 random samples
        st[2] = 1'b1; tick(); st[2] = 1'b0;
        model = 16'hFFFF;
        for (int i = 0; i < 100; i++) begin
            feed(vecs[i]);
            model = mstep(model, vecs[i]);
        end
        r100 = model;
        st_chk(2, 1, 0, 100, model, "t4_mid");
        rst = 1'b1; tick(); rst = 1'b0;
        st_chk(2, 0, 0, 0, 16'hFFFF, "t4_reset");
        // T6: clean run of 256 random vectors, first 100 replayed
        st[2] = 1'b1; tick(); st[2] = 1'b0;
        model = 16'hFFFF;
        for (int i = 0; i < 256; i++) begin
            feed(vecs[i]);
            model = mstep(model, vecs[i]);
            if (i == 99) chk("t4_replay_sig", sg[2], r100);
            if (i % 64 == 31) st_chk(2, 1, 0, 16'(i + 1), model, "t6_prog");
        end
        st_chk(2, 0, 1, 256, model, "t6_final");
        rv[2] = 1'b1; st[2] = 1'b1; ri[2] = 11'h7FF; tick(); rv[2] = 1'b0; st[2] = 1'b0;
        st_chk(2, 0, 1, 256, model, "t6_hold_ignore");
        rdy[2] = 1'b1; tick(); rdy[2] = 1'b0;
        st_chk(2, 0, 0, 256, model, "t6_release");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
